// File: rtl/debounce_edge_pkg.sv
// Shared constants and helpers for the debounce_edge per-bit debouncer.
package debounce_edge_pkg;

  localparam int unsigned DefaultWidth = 3;
  localparam int unsigned DefaultCount = 4;

  // Counter width able to hold 0..count; clamps to 1 so an illegal COUNT still elaborates far
  // enough to report its own error.
  function automatic int unsigned cnt_w(input int unsigned count);
    return (count < 1) ? 1 : $clog2(count + 1);
  endfunction

endpackage

// File: rtl/debounce_edge_bit.sv
// Single-channel debouncer: level register, run-length counter and registered edge strobes.
// Optional push-on/push-off toggle output when DEBOUNCE_EDGE_TOGGLE_EN is defined.
module debounce_edge_bit
  import debounce_edge_pkg::*;
#(
  parameter int unsigned COUNT = DefaultCount,
  parameter logic        INIT  = 1'b0
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_input,
  output logic o_state,
  output logic o_rise,
  output logic o_fall
);

  localparam int unsigned CntW = cnt_w(COUNT);
  localparam logic [CntW-1:0] CntLast = CntW'(COUNT - 1);

  logic            s_q;
  logic [CntW-1:0] c_q;
  logic            rise_q;
  logic            fall_q;
  logic            accept;

  // The input has disagreed with the level for COUNT consecutive edges, including this one.
  assign accept = (i_input != s_q) && (c_q == CntLast);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      s_q    <= INIT;
      c_q    <= '0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      if (i_input == s_q) begin
        c_q <= '0;
      end else if (!accept) begin
        c_q <= c_q + 1'b1;
      end else begin
        s_q    <= i_input;
        c_q    <= '0;
        rise_q <= i_input;
        fall_q <= ~i_input;
      end
    end
  end

`ifdef DEBOUNCE_EDGE_TOGGLE_EN
  logic t_q;

  // Flips on the same edge that raises the rise strobe, so state and strobe appear together.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      t_q <= 1'b0;
    end else if (accept && i_input) begin
      t_q <= ~t_q;
    end
  end

  assign o_state = t_q;
`else
  assign o_state = s_q;
`endif

  assign o_rise = rise_q;
  assign o_fall = fall_q;

endmodule

// File: rtl/debounce_edge.sv
// Per-bit debouncer and edge detector for inputs already synchronized to i_clk.
// Define DEBOUNCE_EDGE_TOGGLE_EN to make ov_state a push-on/push-off toggle per bit.
module debounce_edge
  import debounce_edge_pkg::*;
#(
  parameter int unsigned       WIDTH = DefaultWidth,
  parameter int unsigned       COUNT = DefaultCount,
  parameter logic [WIDTH-1:0]  INIT  = {WIDTH{1'b0}}
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [WIDTH-1:0] iv_input,
  output logic [WIDTH-1:0] ov_state,
  output logic [WIDTH-1:0] ov_rise,
  output logic [WIDTH-1:0] ov_fall
);

  if (COUNT < 1 || WIDTH < 1) begin : gen_param_check
    $error("debounce_edge: COUNT and WIDTH must both be at least 1");
  end

  for (genvar i = 0; i < WIDTH; i++) begin : gen_bit
    debounce_edge_bit #(
      .COUNT (COUNT),
      .INIT  (INIT[i])
    ) u_bit (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_input (iv_input[i]),
      .o_state (ov_state[i]),
      .o_rise  (ov_rise[i]),
      .o_fall  (ov_fall[i])
    );
  end

endmodule

// File: tb/tb_debounce_edge.sv
// Directed self-checking bench for debounce_edge at WIDTH=3, COUNT=4, INIT=0.
module tb_debounce_edge;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] din = 3'b000;
  logic [2:0] st;
  logic [2:0] ri;
  logic [2:0] fa;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [2:0] din;
    logic [2:0] st;
    logic [2:0] st_tog;
    logic [2:0] ri;
    logic [2:0] fa;
  } vec_t;

  vec_t vecs[28];

  debounce_edge #(
    .WIDTH (3),
    .COUNT (4),
    .INIT  (3'b000)
  ) dut (
    .i_clk    (clk),
    .i_reset  (rst),
    .iv_input (din),
    .ov_state (st),
    .ov_rise  (ri),
    .ov_fall  (fa)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [2:0] act, input logic [2:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // One rising edge, then park on the falling edge for sampling and driving.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_all(input string tag, input logic [2:0] e_st, input logic [2:0] e_ri,
                           input logic [2:0] e_fa);
    check({tag, " state"}, st, e_st);
    check({tag, " rise"}, ri, e_ri);
    check({tag, " fall"}, fa, e_fa);
  endtask

  initial begin
    logic [2:0] exp_st;

    // Each row: input applied before an edge, outputs expected just after it.
    vecs[0]  = '{3'b001, 3'b000, 3'b000, 3'b000, 3'b000};
    vecs[1]  = '{3'b001, 3'b000, 3'b000, 3'b000, 3'b000};
    vecs[2]  = '{3'b001, 3'b000, 3'b000, 3'b000, 3'b000};
    vecs[3]  = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b000};
    vecs[4]  = '{3'b001, 3'b001, 3'b001, 3'b000, 3'b000};
    vecs[5]  = '{3'b000, 3'b001, 3'b001, 3'b000, 3'b000};
    vecs[6]  = '{3'b000, 3'b001, 3'b001, 3'b000, 3'b000};
    vecs[7]  = '{3'b000, 3'b001, 3'b001, 3'b000, 3'b000};
    vecs[8]  = '{3'b000, 3'b000, 3'b001, 3'b000, 3'b001};
    vecs[9]  = '{3'b000, 3'b000, 3'b001, 3'b000, 3'b000};
    vecs[10] = '{3'b010, 3'b000, 3'b001, 3'b000, 3'b000};
    vecs[11] = '{3'b010, 3'b000, 3'b001, 3'b000, 3'b000};
    vecs[12] = '{3'b010, 3'b000, 3'b001, 3'b000, 3'b000};
    vecs[13] = '{3'b000, 3'b000, 3'b001, 3'b000, 3'b000};
    vecs[14] = '{3'b010, 3'b000, 3'b001, 3'b000, 3'b000};
    vecs[15] = '{3'b010, 3'b000, 3'b001, 3'b000, 3'b000};
    vecs[16] = '{3'b010, 3'b000, 3'b001, 3'b000, 3'b000};
    vecs[17] = '{3'b000, 3'b000, 3'b001, 3'b000, 3'b000};
    vecs[18] = '{3'b100, 3'b000, 3'b001, 3'b000, 3'b000};
    vecs[19] = '{3'b100, 3'b000, 3'b001, 3'b000, 3'b000};
    vecs[20] = '{3'b100, 3'b000, 3'b001, 3'b000, 3'b000};
    vecs[21] = '{3'b100, 3'b100, 3'b101, 3'b100, 3'b000};
    vecs[22] = '{3'b100, 3'b100, 3'b101, 3'b000, 3'b000};
    vecs[23] = '{3'b001, 3'b100, 3'b101, 3'b000, 3'b000};
    vecs[24] = '{3'b001, 3'b100, 3'b101, 3'b000, 3'b000};
    vecs[25] = '{3'b001, 3'b100, 3'b101, 3'b000, 3'b000};
    vecs[26] = '{3'b001, 3'b001, 3'b100, 3'b001, 3'b100};
    vecs[27] = '{3'b001, 3'b001, 3'b100, 3'b000, 3'b000};

    // Reset held with all inputs high, then released: no strobe until 4 edges pass.
    din = 3'b111;
    step();
    step();
    check_all("reset held", 3'b000, 3'b000, 3'b000);
    rst = 1'b0;
    step();
    check_all("release e1", 3'b000, 3'b000, 3'b000);
    step();
    check_all("release e2", 3'b000, 3'b000, 3'b000);
    step();
    check_all("release e3", 3'b000, 3'b000, 3'b000);
    step();
    check_all("release e4", 3'b111, 3'b111, 3'b000);
    step();
    check_all("release e5", 3'b111, 3'b000, 3'b000);

    // Asynchronous assertion between edges clears outputs without a clock.
    #2 rst = 1'b1;
    #1 check_all("async reset", 3'b000, 3'b000, 3'b000);
    din = 3'b000;
    step();
    rst = 1'b0;

    for (int i = 0; i < 28; i++) begin
      din = vecs[i].din;
      step();
`ifdef DEBOUNCE_EDGE_TOGGLE_EN
      exp_st = vecs[i].st_tog;
`else
      exp_st = vecs[i].st;
`endif
      check_all($sformatf("vec%0d", i + 1), exp_st, vecs[i].ri, vecs[i].fa);
    end

    // Reset mid-count discards partial progress.
    rst = 1'b1;
    din = 3'b000;
    step();
    rst = 1'b0;
    din = 3'b001;
    step();
    step();
    check_all("midcount pre", 3'b000, 3'b000, 3'b000);
    #2 rst = 1'b1;
    #1 check("midcount async", st, 3'b000);
    step();
    rst = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      step();
      check_all($sformatf("midcount e%0d", k), 3'b000, 3'b000, 3'b000);
    end
    step();
    check_all("midcount e4", 3'b001, 3'b001, 3'b000);

    // Reset in a strobe cycle kills the strobe immediately.
    #2 rst = 1'b1;
    #1 check_all("strobe reset", 3'b000, 3'b000, 3'b000);
    step();
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
